// File: rtl/pcs_tx_gearbox_ctrl_if.sv
// pcs_tx_gearbox_ctrl_if
// XGMII transmit stream from the MAC into the gearbox scheduler.
//   s_xgmii_txd   : MAC data word, lane 0 in bits [7:0]
//   s_xgmii_txc   : MAC control flags, one per lane
//   s_xgmii_valid : MAC word present
//   s_xgmii_ready : scheduler accepts the word on an edge where valid && ready
// Modports: master = MAC side, slave = scheduler side.
interface pcs_tx_gearbox_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] s_xgmii_txd;
  logic [CTRL_WIDTH-1:0] s_xgmii_txc;
  logic                  s_xgmii_valid;
  logic                  s_xgmii_ready;

  modport master (
    output s_xgmii_txd,
    output s_xgmii_txc,
    output s_xgmii_valid,
    input  s_xgmii_ready
  );

  modport slave (
    input  s_xgmii_txd,
    input  s_xgmii_txc,
    input  s_xgmii_valid,
    output s_xgmii_ready
  );
endinterface

// File: rtl/pcs_tx_gearbox_ctrl.sv
// pcs_tx_gearbox_ctrl
// Transmit-side scheduler between the 32-bit XGMII MAC stream and the 64b/66b
// encoder. Inserts one gearbox pause slot every GB_PERIOD cycles, tracks the
// lower/upper half-block phase, fills idle slots with /I/, substitutes /E/ when
// the MAC underruns mid-block, and sends Local Fault ordered sets on request.
//
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   mac              : MAC stream (slave side of pcs_tx_gearbox_ctrl_if)
//   i_tx_enable      : DATA mode when high, IDLE mode when low
//   i_send_lf        : LF mode, overrides i_tx_enable
//   o_xgmii_txd/txc  : registered word and control flags to the encoder
//   o_xgmii_valid    : encoder input valid, low only after a pause slot
//   o_xgmii_pause    : encoder stalled
//   o_word_phase     : phase of the last word output (0 lower, 1 upper)
//   o_gb_cnt         : current gearbox slot 0..GB_PERIOD-1
//   o_underrun       : one-cycle pulse when /E/ is inserted
//
// Mode FSM:
//   state     | meaning
//   MODE_IDLE | every data slot carries the idle word 0x07070707 / 0xF
//   MODE_DATA | MAC words pass through; /I/ fill when absent, /E/ on underrun
//   MODE_LF   | both halves of every block carry the Local Fault ordered set
module pcs_tx_gearbox_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int GB_PERIOD  = 33
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  pcs_tx_gearbox_ctrl_if.slave  mac,
  input  logic                  i_tx_enable,
  input  logic                  i_send_lf,
  output logic [DATA_WIDTH-1:0] o_xgmii_txd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_txc,
  output logic                  o_xgmii_valid,
  output logic                  o_xgmii_pause,
  output logic                  o_word_phase,
  output logic [5:0]            o_gb_cnt,
  output logic                  o_underrun
);

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_DATA = 2'd1;
  localparam logic [1:0] MODE_LF   = 2'd2;

  localparam logic [5:0] PAUSE_SLOT = 6'(GB_PERIOD - 1);

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(32'h0707_0707);
  localparam logic [DATA_WIDTH-1:0] LF_WORD    = DATA_WIDTH'(32'h0100_009C);
  localparam logic [DATA_WIDTH-1:0] ERROR_WORD = DATA_WIDTH'(32'hFEFE_FEFE);
  localparam logic [CTRL_WIDTH-1:0] CTRL_ALL   = '1;
  localparam logic [CTRL_WIDTH-1:0] CTRL_LANE0 = CTRL_WIDTH'(1);

  logic [5:0] gb_cnt;
  logic       phase;      // phase of the word produced in the current data slot
  logic [1:0] mode;       // mode latched at the last block boundary
  logic       lower_mac;  // lower word of the current block came from the MAC

  logic       is_pause;
  logic       boundary;
  logic [1:0] mode_sel;
  logic [1:0] mode_cur;

  logic [DATA_WIDTH-1:0] nxt_txd;
  logic [CTRL_WIDTH-1:0] nxt_txc;
  logic                  nxt_under;
  logic                  nxt_lower;

  assign is_pause = (gb_cnt == PAUSE_SLOT);
  assign boundary = !is_pause && !phase;

  always_comb begin
    mode_sel = MODE_IDLE;
    if (i_send_lf) begin
      mode_sel = MODE_LF;
    end else if (i_tx_enable) begin
      mode_sel = MODE_DATA;
    end
  end

  // A switch taken at this boundary already governs this slot, including ready.
  assign mode_cur = boundary ? mode_sel : mode;

  assign mac.s_xgmii_ready = i_reset_n && (mode_cur == MODE_DATA) && !is_pause;

  always_comb begin
    nxt_txd   = IDLE_WORD;
    nxt_txc   = CTRL_ALL;
    nxt_under = 1'b0;
    nxt_lower = 1'b0;
    case (mode_cur)
      MODE_LF: begin
        nxt_txd = LF_WORD;
        nxt_txc = CTRL_LANE0;
      end
      MODE_DATA: begin
        if (mac.s_xgmii_valid) begin
          nxt_txd   = mac.s_xgmii_txd;
          nxt_txc   = mac.s_xgmii_txc;
          nxt_lower = !phase;
        end else if (phase && lower_mac) begin
          // The block was opened with MAC data and cannot be closed with /I/.
          nxt_txd   = ERROR_WORD;
          nxt_under = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      gb_cnt        <= '0;
      phase         <= 1'b0;
      mode          <= MODE_IDLE;
      lower_mac     <= 1'b0;
      o_xgmii_txd   <= IDLE_WORD;
      o_xgmii_txc   <= CTRL_ALL;
      o_xgmii_valid <= 1'b0;
      o_xgmii_pause <= 1'b0;
      o_underrun    <= 1'b0;
      o_word_phase  <= 1'b0;
    end else begin
      gb_cnt <= is_pause ? 6'd0 : gb_cnt + 6'd1;
      if (is_pause) begin
        // txd/txc/word_phase hold so the encoder sees a stable word while stalled.
        o_xgmii_valid <= 1'b0;
        o_xgmii_pause <= 1'b1;
        o_underrun    <= 1'b0;
      end else begin
        o_xgmii_txd   <= nxt_txd;
        o_xgmii_txc   <= nxt_txc;
        o_xgmii_valid <= 1'b1;
        o_xgmii_pause <= 1'b0;
        o_underrun    <= nxt_under;
        o_word_phase  <= phase;
        phase         <= ~phase;
        mode          <= mode_cur;
        lower_mac     <= nxt_lower;
      end
    end
  end

  assign o_gb_cnt = gb_cnt;

endmodule

// File: tb/tb_pcs_tx_gearbox_ctrl.sv
module tb_pcs_tx_gearbox_ctrl;

  localparam logic [31:0] IDLE_W = 32'h0707_0707;
  localparam logic [31:0] LF_W   = 32'h0100_009C;
  localparam logic [31:0] E_W    = 32'hFEFE_FEFE;
  localparam int M_IDLE = 0;
  localparam int M_DATA = 1;
  localparam int M_LF   = 2;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_tx_enable;
  logic        i_send_lf;
  logic [31:0] o_xgmii_txd;
  logic [3:0]  o_xgmii_txc;
  logic        o_xgmii_valid;
  logic        o_xgmii_pause;
  logic        o_word_phase;
  logic [5:0]  o_gb_cnt;
  logic        o_underrun;

  pcs_tx_gearbox_ctrl_if mac_if ();

  pcs_tx_gearbox_ctrl dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .mac           (mac_if.slave),
    .i_tx_enable   (i_tx_enable),
    .i_send_lf     (i_send_lf),
    .o_xgmii_txd   (o_xgmii_txd),
    .o_xgmii_txc   (o_xgmii_txc),
    .o_xgmii_valid (o_xgmii_valid),
    .o_xgmii_pause (o_xgmii_pause),
    .o_word_phase  (o_word_phase),
    .o_gb_cnt      (o_gb_cnt),
    .o_underrun    (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: slot number since reset, block phase = slot parity.
  int          m_slot  = 0;
  int          m_mode  = M_IDLE;
  bit          m_lower = 1'b0;
  logic [31:0] e_txd   = IDLE_W;
  logic [3:0]  e_txc   = 4'hF;
  logic        e_valid = 1'b0;
  logic        e_pause = 1'b0;
  logic        e_under = 1'b0;
  logic        e_phase = 1'b0;
  bit          acc_last = 1'b0;

  function automatic int pick_mode();
    if (i_send_lf) return M_LF;
    if (i_tx_enable) return M_DATA;
    return M_IDLE;
  endfunction

  function automatic logic exp_ready();
    int md;
    if (!i_reset_n || m_slot == 32) return 1'b0;
    md = (m_slot % 2 == 0) ? pick_mode() : m_mode;
    return (md == M_DATA);
  endfunction

  task automatic model_edge();
    int ph;
    acc_last = 1'b0;
    if (!i_reset_n) begin
      m_slot = 0; m_mode = M_IDLE; m_lower = 1'b0;
      e_txd = IDLE_W; e_txc = 4'hF;
      e_valid = 1'b0; e_pause = 1'b0; e_under = 1'b0; e_phase = 1'b0;
    end else if (m_slot == 32) begin
      e_valid = 1'b0; e_pause = 1'b1; e_under = 1'b0;
      m_slot = 0;
    end else begin
      ph = m_slot % 2;
      if (ph == 0) m_mode = pick_mode();
      e_valid = 1'b1; e_pause = 1'b0; e_under = 1'b0; e_phase = (ph == 1);
      e_txd = IDLE_W; e_txc = 4'hF;
      if (m_mode == M_LF) begin
        e_txd = LF_W; e_txc = 4'h1;
      end else if (m_mode == M_DATA) begin
        if (mac_if.s_xgmii_valid) begin
          e_txd = mac_if.s_xgmii_txd; e_txc = mac_if.s_xgmii_txc; acc_last = 1'b1;
        end else if (ph == 1 && m_lower) begin
          e_txd = E_W; e_under = 1'b1;
        end
      end
      if (ph == 0) m_lower = (m_mode == M_DATA) && mac_if.s_xgmii_valid;
      m_slot++;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic drive(input logic en, input logic lf, input logic v,
                       input logic [31:0] d, input logic [3:0] c);
    i_tx_enable = en;
    i_send_lf   = lf;
    mac_if.s_xgmii_valid = v;
    mac_if.s_xgmii_txd   = d;
    mac_if.s_xgmii_txc   = c;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    i_reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) tick();
      else begin i_reset_n = 1'b1; #1; end
      total++; if (o_xgmii_txd !== IDLE_W) begin bad++; $display("FAIL rst_txd[%0d]: got %h want %h", i, o_xgmii_txd, IDLE_W); end
      total++; if (o_xgmii_txc !== 4'hF) begin bad++; $display("FAIL rst_txc[%0d]: got %h want f", i, o_xgmii_txc); end
      total++; if ({o_xgmii_valid, o_xgmii_pause, o_underrun, o_word_phase} !== 4'b0) begin bad++; $display("FAIL rst_flags[%0d]: got %b want 0000", i, {o_xgmii_valid, o_xgmii_pause, o_underrun, o_word_phase}); end
      total++; if (o_gb_cnt !== 6'd0) begin bad++; $display("FAIL rst_gb_cnt[%0d]: got %0d want 0", i, o_gb_cnt); end
      total++; if (mac_if.s_xgmii_ready !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d]: got %b want 0", i, mac_if.s_xgmii_ready); end
    end
  endtask

  task automatic test_idle();
    int n_pause = 0;
    int n_idle  = 0;
    for (int i = 0; i < 66; i++) begin
      tick();
      if (o_xgmii_pause === 1'b1) n_pause++;
      if (o_xgmii_valid === 1'b1 && o_xgmii_txd === IDLE_W && o_xgmii_txc === 4'hF) n_idle++;
      total++; if (o_xgmii_txd !== e_txd || o_xgmii_txc !== e_txc) begin bad++; $display("FAIL idle_word: got %h/%h want %h/%h", o_xgmii_txd, o_xgmii_txc, e_txd, e_txc); end
      total++; if (o_xgmii_valid !== e_valid || o_xgmii_pause !== e_pause) begin bad++; $display("FAIL idle_vp: got %b%b want %b%b", o_xgmii_valid, o_xgmii_pause, e_valid, e_pause); end
      total++; if (o_word_phase !== e_phase) begin bad++; $display("FAIL idle_phase: got %b want %b", o_word_phase, e_phase); end
      total++; if (o_gb_cnt !== 6'(m_slot)) begin bad++; $display("FAIL idle_gb_cnt: got %0d want %0d", o_gb_cnt, m_slot); end
    end
    total++; if (n_pause != 2) begin bad++; $display("FAIL idle_pause_count: got %0d want 2", n_pause); end
    total++; if (n_idle != 64) begin bad++; $display("FAIL idle_word_count: got %0d want 64", n_idle); end
  endtask

  task automatic test_stream();
    int n = 0;
    int out_n = 0;
    int rdy_in_pause = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'(n), 4'h0);
      #1;
      if (m_slot == 32 && mac_if.s_xgmii_ready !== 1'b0) rdy_in_pause++;
      total++; if (mac_if.s_xgmii_ready !== exp_ready()) begin bad++; $display("FAIL stream_ready: got %b want %b slot %0d", mac_if.s_xgmii_ready, exp_ready(), m_slot); end
      tick();
      if (acc_last) n++;
      if (o_xgmii_valid === 1'b1 && o_xgmii_txc === 4'h0) begin
        total++; if (o_xgmii_txd !== 32'(out_n)) begin bad++; $display("FAIL stream_order: got %h want %h", o_xgmii_txd, 32'(out_n)); end
        out_n++;
      end
      total++; if (o_xgmii_valid !== e_valid || o_xgmii_pause !== e_pause) begin bad++; $display("FAIL stream_vp: got %b%b want %b%b", o_xgmii_valid, o_xgmii_pause, e_valid, e_pause); end
    end
    total++; if (out_n != n) begin bad++; $display("FAIL stream_count: got %0d want %0d", out_n, n); end
    total++; if (n < 950) begin bad++; $display("FAIL stream_throughput: got %0d want >=950", n); end
    total++; if (rdy_in_pause != 0) begin bad++; $display("FAIL stream_ready_pause: got %0d want 0", rdy_in_pause); end
  endtask

  task automatic test_underrun();
    int n_under = 0;
    int guard = 0;
    drive(1'b1, 1'b0, 1'b1, 32'hCAFE_0000, 4'h0);
    while (!(m_slot % 2 == 0 && m_slot < 32) && guard < 40) begin tick(); guard++; end
    drive(1'b1, 1'b0, 1'b1, 32'hA5A5_1234, 4'h0);
    tick();
    total++; if (o_xgmii_txd !== 32'hA5A5_1234 || o_xgmii_txc !== 4'h0) begin bad++; $display("FAIL urun_lower: got %h/%h want a5a51234/0", o_xgmii_txd, o_xgmii_txc); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    tick();
    if (o_underrun === 1'b1) n_under++;
    total++; if (o_xgmii_txd !== E_W || o_xgmii_txc !== 4'hF) begin bad++; $display("FAIL urun_word: got %h/%h want fefefefe/f", o_xgmii_txd, o_xgmii_txc); end
    total++; if (o_underrun !== 1'b1) begin bad++; $display("FAIL urun_pulse: got %b want 1", o_underrun); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_underrun === 1'b1) n_under++;
      total++; if (o_xgmii_txd !== e_txd || o_underrun !== e_under) begin bad++; $display("FAIL urun_after: got %h/%b want %h/%b", o_xgmii_txd, o_underrun, e_txd, e_under); end
    end
    total++; if (n_under != 1) begin bad++; $display("FAIL urun_count: got %0d want 1", n_under); end
  endtask

  task automatic test_lf();
    int guard = 0;
    int n_lf = 0;
    drive(1'b1, 1'b0, 1'b1, 32'h1000_0000, 4'h0);
    while (!(m_slot % 2 == 1 && m_slot < 31) && guard < 40) begin tick(); guard++; end
    drive(1'b1, 1'b1, 1'b1, 32'h1000_0001, 4'h0);
    tick();
    total++; if (o_xgmii_txd !== 32'h1000_0001 || o_xgmii_txc !== 4'h0) begin bad++; $display("FAIL lf_finish_block: got %h/%h want 10000001/0", o_xgmii_txd, o_xgmii_txc); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (o_xgmii_txd !== LF_W || o_xgmii_txc !== 4'h1) begin bad++; $display("FAIL lf_half%0d: got %h/%h want 0100009c/1", i, o_xgmii_txd, o_xgmii_txc); end
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_xgmii_valid === 1'b1 && o_xgmii_txd === LF_W) n_lf++;
      total++; if (o_xgmii_txd !== e_txd || o_xgmii_txc !== e_txc) begin bad++; $display("FAIL lf_hold: got %h/%h want %h/%h", o_xgmii_txd, o_xgmii_txc, e_txd, e_txc); end
    end
    total++; if (n_lf < 11) begin bad++; $display("FAIL lf_persist: got %0d want >=11", n_lf); end
    guard = 0;
    while (!(m_slot % 2 == 1 && m_slot < 31) && guard < 40) begin tick(); guard++; end
    drive(1'b1, 1'b0, 1'b1, 32'h2000_0000, 4'h0);
    tick();
    total++; if (o_xgmii_txd !== LF_W) begin bad++; $display("FAIL lf_drop_upper: got %h want 0100009c", o_xgmii_txd); end
    tick();
    total++; if (o_xgmii_txd !== 32'h2000_0000 || o_xgmii_txc !== 4'h0) begin bad++; $display("FAIL lf_back_to_data: got %h/%h want 20000000/0", o_xgmii_txd, o_xgmii_txc); end
  endtask

  task automatic test_random();
    logic en = 1'b1;
    logic lf = 1'b0;
    logic v  = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (m_slot % 2 == 0) begin
        en = ($urandom_range(0, 3) != 0);
        lf = ($urandom_range(0, 9) == 0);
        v  = ($urandom_range(0, 3) != 0);
      end else if ($urandom_range(0, 7) == 0) begin
        v = 1'b0;
      end
      drive(en, lf, v, $urandom, 4'($urandom_range(0, 15)));
      #1;
      total++; if (mac_if.s_xgmii_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready: got %b want %b slot %0d", mac_if.s_xgmii_ready, exp_ready(), m_slot); end
      tick();
      total++; if (o_xgmii_txd !== e_txd || o_xgmii_txc !== e_txc) begin bad++; $display("FAIL rand_word: got %h/%h want %h/%h", o_xgmii_txd, o_xgmii_txc, e_txd, e_txc); end
      total++; if ({o_xgmii_valid, o_xgmii_pause, o_underrun, o_word_phase} !== {e_valid, e_pause, e_under, e_phase}) begin bad++; $display("FAIL rand_flags: got %b want %b", {o_xgmii_valid, o_xgmii_pause, o_underrun, o_word_phase}, {e_valid, e_pause, e_under, e_phase}); end
      total++; if (o_gb_cnt !== 6'(m_slot)) begin bad++; $display("FAIL rand_gb_cnt: got %0d want %0d", o_gb_cnt, m_slot); end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int k = 0;
    drive(1'b1, 1'b0, 1'b1, 32'h3000_0000, 4'h0);
    while (m_slot != 17 && guard < 40) begin tick(); guard++; end
    total++; if (o_gb_cnt !== 6'd17) begin bad++; $display("FAIL rmid_reach17: got %0d want 17", o_gb_cnt); end
    i_reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (o_xgmii_txd !== IDLE_W || o_underrun !== 1'b0 || o_xgmii_valid !== 1'b0) begin bad++; $display("FAIL rmid_outputs[%0d]: got %h/%b/%b want 07070707/0/0", i, o_xgmii_txd, o_underrun, o_xgmii_valid); end
      total++; if (o_gb_cnt !== 6'd0) begin bad++; $display("FAIL rmid_gb_cnt[%0d]: got %0d want 0", i, o_gb_cnt); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    i_reset_n = 1'b1;
    #1;
    total++; if (o_gb_cnt !== 6'd0 || mac_if.s_xgmii_ready !== 1'b0) begin bad++; $display("FAIL rmid_release: got cnt %0d rdy %b want 0 0", o_gb_cnt, mac_if.s_xgmii_ready); end
    while (o_xgmii_pause !== 1'b1 && k < 40) begin tick(); k++; end
    total++; if (k != 33) begin bad++; $display("FAIL rmid_first_pause: got %0d want 33", k); end
  endtask

  initial begin
    i_reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    @(negedge i_clk);
    test_reset();
    tick();
    total++; if (o_xgmii_valid !== 1'b1 || o_gb_cnt !== 6'd1) begin bad++; $display("FAIL first_valid: got v %b cnt %0d want 1 1", o_xgmii_valid, o_gb_cnt); end
    test_idle();
    test_stream();
    test_underrun();
    test_lf();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
